sample_frame_streamer: RTL and testbench

Parametrised multi-channel output stage for the synthesizer. It accepts mixed samples from the mixer one channel at a time and assembles them into frames in a ring buffer. At a programmable sample rate it pops one frame into a held DAC register and streams the same frame to the mSGDMA over Avalon-ST with ready/valid backpressure. It replaces the fixed 10-entry, mono, dual-clock ring buffer with a single-clock design paced by a clock enable, with explicit full/empty/underrun handling and status counters.

---
 rtl/sample_frame_streamer.sv | 193 +++++++++++++++++++
 tb/tb_sample_frame_streamer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_frame_streamer.sv
// Multi-channel output stage: assembles mixer samples into frames in a ring buffer and pops one frame per sample tick.
// Each popped frame goes to a held DAC register and out as an Avalon-ST packet.
// Build option SAMPLE_STREAM_ZERO_UNDERRUN_EN: underrun outputs silence instead of repeating the last frame.
module sample_frame_streamer #(
   parameter  int SAMPLE_W = 24,
   parameter  int NCHAN    = 2,
   parameter  int DEPTH    = 16,
   parameter  int CLK_DIV  = 521,
   localparam int CHW      = (NCHAN > 1) ? $clog2(NCHAN) : 1,
   localparam int AW       = $clog2(DEPTH),
   localparam int LW       = AW + 1,
   localparam int FW       = SAMPLE_W * NCHAN,
   localparam int TW       = $clog2(CLK_DIV)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic signed [SAMPLE_W-1:0] i_sample,
   input  logic [CHW-1:0]             i_chan,
   input  logic                       i_valid,
   output logic                       o_ready,
   output logic                       o_tick,
   output logic [FW-1:0]              o_dac,
   output logic [31:0]                aso_data,
   output logic [CHW-1:0]             aso_channel,
   output logic                       aso_startofpacket,
   output logic                       aso_endofpacket,
   output logic                       aso_valid,
   input  logic                       aso_ready,
   output logic [LW-1:0]              o_level,
   output logic [15:0]                o_underrun_cnt,
   output logic [15:0]                o_drop_cnt,
   output logic                       o_sync_err
);

   typedef enum logic {S_IDLE, S_STREAM} state_t;

   state_t                      r_state, w_state_next;
   logic [TW-1:0]               r_tick_cnt;
   logic [CHW-1:0]              r_expected;
   logic signed [SAMPLE_W-1:0]  r_asm [NCHAN];
   logic                        r_sync_err;
   logic [FW-1:0]               r_mem [DEPTH];
   logic [AW-1:0]               r_wptr, r_rptr;
   logic [LW-1:0]               r_level;
   logic [FW-1:0]               r_dac, r_sframe;
   logic [15:0]                 r_underrun_cnt, r_drop_cnt;
   logic [CHW-1:0]              r_beat;

   logic                        w_tick, w_hs, w_match, w_last, w_commit, w_pop, w_beat_last;
   logic [FW-1:0]               w_commit_frame, w_out_frame;
   logic signed [SAMPLE_W-1:0]  w_beat_sample;

   // ---------------- sample-rate tick ----------------
   assign w_tick = (r_tick_cnt == TW'(CLK_DIV - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       r_tick_cnt <= '0;
      else if (w_tick) r_tick_cnt <= '0;
      else             r_tick_cnt <= r_tick_cnt + TW'(1);
   end

   // ---------------- frame assembly ----------------
   assign w_hs     = i_valid && o_ready;
   assign w_match  = (i_chan == r_expected);
   assign w_last   = (r_expected == CHW'(NCHAN - 1));
   assign w_commit = w_hs && w_match && w_last;

   // NOTE: combinational blocks assign every output a default first so no latch is inferred.
   always_comb begin
      w_commit_frame = '0;
      for (int i = 0; i < NCHAN; i++)
         w_commit_frame[i*SAMPLE_W +: SAMPLE_W] = (i == NCHAN - 1) ? i_sample : r_asm[i];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_expected <= '0;
         r_sync_err <= 1'b0;
         for (int i = 0; i < NCHAN; i++) r_asm[i] <= '0;
      end else begin
         r_sync_err <= 1'b0;
         if (w_hs) begin
            if (w_match) begin
               r_asm[r_expected] <= i_sample;
               r_expected        <= w_last ? '0 : r_expected + CHW'(1);
            end else begin
               // Out-of-order channel: discard partial frame, resync on a channel-0 sample.
               r_sync_err <= 1'b1;
               if (i_chan == '0) begin
                  r_asm[0]   <= i_sample;
                  r_expected <= CHW'(1);
               end else begin
                  r_expected <= '0;
               end
            end
         end
      end
   end

   // ---------------- ring buffer ----------------
   // NOTE: the frame storage has no reset; pointers and level define which entries are valid.
   always_ff @(posedge clk) begin
      if (w_commit) r_mem[r_wptr] <= w_commit_frame;
   end

   assign w_pop   = w_tick && (r_level != '0);
   assign o_ready = (r_level < LW'(DEPTH));

   always_comb begin
      w_out_frame = r_mem[r_rptr];
      if (!w_pop) begin
`ifdef SAMPLE_STREAM_ZERO_UNDERRUN_EN
         w_out_frame = '0;
`else
         w_out_frame = r_dac;
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr         <= '0;
         r_rptr         <= '0;
         r_level        <= '0;
         r_dac          <= '0;
         r_underrun_cnt <= '0;
         r_drop_cnt     <= '0;
      end else begin
         if (w_commit) r_wptr <= r_wptr + AW'(1);
         if (w_pop)    r_rptr <= r_rptr + AW'(1);
         if (w_commit && !w_pop)      r_level <= r_level + LW'(1);
         else if (!w_commit && w_pop) r_level <= r_level - LW'(1);
         if (w_tick) r_dac <= w_out_frame;
         if (w_tick && !w_pop && r_underrun_cnt != 16'hFFFF)
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
         if (w_tick && r_state == S_STREAM && r_drop_cnt != 16'hFFFF)
            r_drop_cnt <= r_drop_cnt + 16'd1;
      end
   end

   // ---------------- Avalon-ST packet FSM ----------------
   assign w_beat_last = (r_beat == CHW'(NCHAN - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next      = r_state;
      aso_valid         = 1'b0;
      aso_startofpacket = 1'b0;
      aso_endofpacket   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_tick) w_state_next = S_STREAM;
         end
         S_STREAM: begin
            aso_valid         = 1'b1;
            aso_startofpacket = (r_beat == '0);
            aso_endofpacket   = w_beat_last;
            if (aso_ready && w_beat_last) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // A tick while streaming leaves the snapshot alone, so the current packet finishes intact.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_beat   <= '0;
         r_sframe <= '0;
      end else if (r_state == S_IDLE) begin
         if (w_tick) begin
            r_beat   <= '0;
            r_sframe <= w_out_frame;
         end
      end else if (aso_ready) begin
         r_beat <= w_beat_last ? '0 : r_beat + CHW'(1);
      end
   end

   assign w_beat_sample  = r_sframe[r_beat*SAMPLE_W +: SAMPLE_W];
   assign aso_data       = 32'(w_beat_sample);
   assign aso_channel    = r_beat;
   assign o_tick         = w_tick;
   assign o_dac          = r_dac;
   assign o_level        = r_level;
   assign o_underrun_cnt = r_underrun_cnt;
   assign o_drop_cnt     = r_drop_cnt;
   assign o_sync_err     = r_sync_err;

endmodule

// File: tb/tb_sample_frame_streamer.sv
// Self-checking bench for sample_frame_streamer: directed scenarios plus random traffic,
// compared every cycle against a queue-based frame model.
module tb_sample_frame_streamer;
   localparam int SW  = 24;
   localparam int NC  = 2;
   localparam int DP  = 8;
   localparam int CD  = 8;
   localparam int CHW = 1;
   localparam int LW  = 4;
   localparam int FW  = SW * NC;

   logic               clk = 1'b0;
   logic               reset;
   logic signed [SW-1:0] i_sample;
   logic [CHW-1:0]     i_chan;
   logic               i_valid;
   logic               o_ready, o_tick;
   logic [FW-1:0]      o_dac;
   logic [31:0]        aso_data;
   logic [CHW-1:0]     aso_channel;
   logic               aso_startofpacket, aso_endofpacket, aso_valid, aso_ready;
   logic [LW-1:0]      o_level;
   logic [15:0]        o_underrun_cnt, o_drop_cnt;
   logic               o_sync_err;

   always #5 clk = ~clk;

   sample_frame_streamer #(.SAMPLE_W(SW), .NCHAN(NC), .DEPTH(DP), .CLK_DIV(CD)) dut (
      .clk(clk), .reset(reset),
      .i_sample(i_sample), .i_chan(i_chan), .i_valid(i_valid), .o_ready(o_ready),
      .o_tick(o_tick), .o_dac(o_dac),
      .aso_data(aso_data), .aso_channel(aso_channel),
      .aso_startofpacket(aso_startofpacket), .aso_endofpacket(aso_endofpacket),
      .aso_valid(aso_valid), .aso_ready(aso_ready),
      .o_level(o_level), .o_underrun_cnt(o_underrun_cnt), .o_drop_cnt(o_drop_cnt),
      .o_sync_err(o_sync_err)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [FW-1:0] m_q[$];
   logic [SW-1:0] m_part [NC];
   logic [FW-1:0] m_dac, m_pkt;
   int m_exp, m_cyc, m_under, m_drop, m_beat;
   bit m_sync, m_stream;

   function automatic bit m_tick_now();
      return (m_cyc % CD) == CD - 1;
   endfunction

   function automatic logic [31:0] sext(input logic [SW-1:0] s);
      return {{(32-SW){s[SW-1]}}, s};
   endfunction

   task automatic model_reset();
      m_q.delete();
      for (int c = 0; c < NC; c++) m_part[c] = '0;
      m_dac = '0; m_pkt = '0;
      m_exp = 0; m_cyc = 0; m_under = 0; m_drop = 0; m_beat = 0;
      m_sync = 0; m_stream = 0;
   endtask

   task automatic model_edge();
      bit tick, rdy, was_stream;
      logic [FW-1:0] f;
      tick = m_tick_now();
      rdy = (m_q.size() < DP);
      was_stream = m_stream;
      m_sync = 0;
      if (m_stream && aso_ready) begin
         if (m_beat == NC - 1) begin m_stream = 0; m_beat = 0; end
         else m_beat++;
      end
      if (tick) begin
         if (m_q.size() > 0) f = m_q.pop_front();
         else begin
            if (m_under < 16'hFFFF) m_under++;
`ifdef SAMPLE_STREAM_ZERO_UNDERRUN_EN
            f = '0;
`else
            f = m_dac;
`endif
         end
         m_dac = f;
         if (was_stream) begin
            if (m_drop < 16'hFFFF) m_drop++;
         end else begin
            m_stream = 1; m_beat = 0; m_pkt = f;
         end
      end
      if (i_valid && rdy) begin
         if (int'(i_chan) == m_exp) begin
            m_part[m_exp] = i_sample;
            if (m_exp == NC - 1) begin
               for (int c = 0; c < NC; c++) f[c*SW +: SW] = m_part[c];
               m_q.push_back(f);
               m_exp = 0;
            end else m_exp++;
         end else begin
            m_sync = 1;
            if (i_chan == '0) begin m_part[0] = i_sample; m_exp = 1; end
            else m_exp = 0;
         end
      end
      m_cyc++;
   endtask

   task automatic compare_all();
      check("ready", o_ready, m_q.size() < DP);
      check("tick", o_tick, m_tick_now());
      check("level", o_level, m_q.size());
      check("dac", o_dac, m_dac);
      check("underrun_cnt", o_underrun_cnt, m_under);
      check("drop_cnt", o_drop_cnt, m_drop);
      check("sync_err", o_sync_err, m_sync);
      check("aso_valid", aso_valid, m_stream);
      check("aso_sop", aso_startofpacket, m_stream && m_beat == 0);
      check("aso_eop", aso_endofpacket, m_stream && m_beat == NC - 1);
      if (m_stream) begin
         check("aso_data", aso_data, sext(m_pkt[m_beat*SW +: SW]));
         check("aso_channel", aso_channel, m_beat);
      end
   endtask

   // One clock: compare mid-cycle, advance model on the edge, return 1 time unit after it.
   task automatic step();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic wait_tick();
      for (int k = 0; k < CD && !m_tick_now(); k++) step();
      step();
   endtask

   task automatic send_frame(input logic [FW-1:0] f);
      for (int c = 0; c < NC; c++) begin
         bit acc;
         int g;
         g = 0;
         i_valid = 1'b1;
         i_chan = CHW'(c);
         i_sample = f[c*SW +: SW];
         do begin
            acc = (m_q.size() < DP);
            step();
            g++;
         end while (!acc && g < 4 * CD * DP);
         check("send_timeout", acc, 1'b1);
      end
      i_valid = 1'b0;
   endtask

   task automatic send_raw(input int ch, input logic [SW-1:0] s);
      i_valid = 1'b1;
      i_chan = CHW'(ch);
      i_sample = s;
      step();
      i_valid = 1'b0;
   endtask

   task automatic check_reset_outputs();
      check("rst_ready", o_ready, 1'b1);
      check("rst_tick", o_tick, 1'b0);
      check("rst_dac", o_dac, '0);
      check("rst_level", o_level, '0);
      check("rst_underrun", o_underrun_cnt, '0);
      check("rst_drop", o_drop_cnt, '0);
      check("rst_sync", o_sync_err, 1'b0);
      check("rst_valid", aso_valid, 1'b0);
      check("rst_data", aso_data, '0);
      check("rst_chan", aso_channel, '0);
      check("rst_sop", aso_startofpacket, 1'b0);
      check("rst_eop", aso_endofpacket, 1'b0);
   endtask

   initial begin
      logic [FW-1:0] f1, f2, last;
      logic [SW-1:0] a, b, c;
      int base;

      reset = 1'b1; i_valid = 1'b0; i_chan = '0; i_sample = '0; aso_ready = 1'b1;
      #12;
      check_reset_outputs();
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();

      // Two known frames, popped on successive ticks and streamed.
      send_frame({24'hFFFF00, 24'h000100});
      send_frame({24'h000300, 24'h000200});
      wait_tick();
      check("tp1_dac0", o_dac, 48'hFFFF00_000100);
      check("tp1_beat0", aso_data, 32'h0000_0100);
      check("tp1_sop", aso_startofpacket, 1'b1);
      check("tp1_ch0", aso_channel, 0);
      step();
      check("tp1_beat1", aso_data, 32'hFFFF_FF00);
      check("tp1_eop", aso_endofpacket, 1'b1);
      check("tp1_ch1", aso_channel, 1);
      wait_tick();
      check("tp1_dac1", o_dac, 48'h000300_000200);

      // Fill to DEPTH, then one tick frees a slot.
      for (int g = 0; g < 4 * DP && m_q.size() < DP; g++)
         send_frame({$urandom_range(0, 24'hFFFFFF), $urandom_range(0, 24'hFFFFFF)});
      check("full_level", o_level, DP);
      check("full_ready", o_ready, 1'b0);
      wait_tick();
      check("full_ready_after_tick", o_ready, 1'b1);

      // Drain, then three underrun ticks.
      for (int g = 0; g < 2 * DP && m_q.size() > 0; g++) wait_tick();
      last = m_dac;
      base = m_under;
      for (int t = 0; t < 3; t++) wait_tick();
      check("underrun_cnt3", o_underrun_cnt, base + 3);
`ifdef SAMPLE_STREAM_ZERO_UNDERRUN_EN
      check("underrun_dac", o_dac, '0);
`else
      check("underrun_dac", o_dac, last);
`endif

      // Sink stalled across two ticks: second frame is dropped from the stream but reaches the DAC.
      f1 = {$urandom_range(0, 24'hFFFFFF), $urandom_range(0, 24'hFFFFFF)};
      f2 = {$urandom_range(0, 24'hFFFFFF), $urandom_range(0, 24'hFFFFFF)};
      send_frame(f1);
      send_frame(f2);
      aso_ready = 1'b0;
      wait_tick();
      check("stall_beat0", aso_data, sext(f1[SW-1:0]));
      base = m_drop;
      wait_tick();
      check("stall_drop", o_drop_cnt, base + 1);
      check("stall_dac", o_dac, f2);
      check("stall_beat0_held", aso_data, sext(f1[SW-1:0]));
      check("stall_ch_held", aso_channel, 0);
      aso_ready = 1'b1;

      // Channel sequence 0,0,1: one sync error, frame built from the second ch0 sample.
      wait_tick();
      a = 24'($urandom); b = 24'($urandom); c = 24'($urandom);
      send_raw(0, a);
      send_raw(0, b);
      check("sync_pulse", o_sync_err, 1'b1);
      send_raw(1, c);
      check("sync_pulse_end", o_sync_err, 1'b0);
      wait_tick();
      check("sync_frame", o_dac, {c, b});

      // Random traffic with occasional channel errors and sink backpressure.
      for (int n = 0; n < 300; n++) begin
         i_valid = 1'($urandom_range(0, 1));
         i_chan = ($urandom_range(0, 7) == 0) ? CHW'($urandom_range(0, 1)) : CHW'(m_exp);
         i_sample = 24'($urandom);
         aso_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      i_valid = 1'b0;

      // Reset while holding five frames with a packet stalled mid-stream.
      aso_ready = 1'b0;
      wait_tick();
      for (int g = 0; g < 2 * DP && m_q.size() > 5; g++) wait_tick();
      for (int g = 0; g < 4 * DP && m_q.size() < 5; g++)
         send_frame({$urandom_range(0, 24'hFFFFFF), $urandom_range(0, 24'hFFFFFF)});
      check("pre_reset_level", o_level, 5);
      reset = 1'b1;
      #1;
      check_reset_outputs();
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      aso_ready = 1'b1;
      f1 = {$urandom_range(0, 24'hFFFFFF), $urandom_range(0, 24'hFFFFFF)};
      send_frame(f1);
      wait_tick();
      check("post_reset_first_pop", o_dac, f1);
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
